// File: rtl/relm_fp_pkg.sv
// Shared state encoding and IEEE-754 single field constants for the relm
// float packer.
package relm_fp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0]  EXP_INF   = 8'hFF;
  localparam logic [22:0] QNAN_FRAC = 23'h400000;
  localparam int          EXP_MSB   = 30;
  localparam int          EXP_LSB   = 23;

  // Signed working exponent: wide enough for 0..257 and the deepest left shift.
  localparam int          EW        = 10;

endpackage

// File: rtl/relm_fround.sv
// Round-to-nearest-even of a normalised mantissa (leading one at bit 30) and
// packing into an IEEE-754 single, with saturation to inf and flush to zero.
module relm_fround
  import relm_fp_pkg::*;
(
  input  logic                 i_sign,
  input  logic signed [EW-1:0] i_exp,
  input  logic [31:0]          i_mant,
  output logic [31:0]          o_word,
  output logic                 o_ovf,
  output logic                 o_unf
);

  logic                 w_lsb;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_inc;
  logic [24:0]          w_sum;
  logic signed [EW-1:0] w_exp_r;
  logic                 w_unused;

  assign w_lsb    = i_mant[7];
  assign w_guard  = i_mant[6];
  assign w_sticky = |i_mant[5:0];
  assign w_inc    = w_guard & (w_sticky | w_lsb);

  // A carry into bit 24 means 1.111.. rounded up to 10.000..; the fraction
  // field is then all zeros, so only the exponent needs adjusting.
  assign w_sum   = {1'b0, i_mant[30:7]} + {24'd0, w_inc};
  assign w_exp_r = i_exp + $signed({{(EW-1){1'b0}}, w_sum[24]});

  // The hidden bit and the (always clear) carry bit are not packed.
  assign w_unused = ^{i_mant[31], w_sum[23]};

  // NOTE: every output gets a default first so no path through the
  //       combinational block can leave one unassigned and infer a latch.
  always_comb begin
    o_ovf  = 1'b0;
    o_unf  = 1'b0;
    o_word = {i_sign, w_exp_r[7:0], w_sum[22:0]};
    if (w_exp_r >= $signed(EW'(255))) begin
      o_ovf  = 1'b1;
      o_word = {i_sign, EXP_INF, 23'd0};
    end else if (w_exp_r <= $signed(EW'(0))) begin
      o_unf  = 1'b1;
      o_word = {i_sign, 31'd0};
    end
  end

endmodule

// File: rtl/relm_fpack.sv
// Normalise, round and pack a raw sign/exponent/mantissa triple into an
// IEEE-754 single; one operation in flight, valid/ready on both sides.
module relm_fpack
  import relm_fp_pkg::*;
#(
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] in_a,
  input  logic [WD-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] out_data,
  output logic          out_ovf,
  output logic          out_unf
);

  state_t               r_state;
  state_t               w_next;
  logic                 r_sign;
  logic signed [EW-1:0] r_exp;
  logic [31:0]          r_mant;
  logic [31:0]          r_data;
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_inf;
  logic                 w_zero;
  logic                 w_special;
  logic [31:0]          w_special_word;
  logic                 w_m_zero;
  logic                 w_m_carry;
  logic                 w_m_norm;
  logic                 w_m_coarse;
  logic [31:0]          w_word;
  logic                 w_ovf;
  logic                 w_unf;
  logic                 w_unused;

  assign w_inf     = in_b[22];
  assign w_zero    = in_b[21];
  assign w_special = w_inf | w_zero;
  assign w_unused  = ^in_b[20:0];

  always_comb begin
    if (w_inf && w_zero) begin
      w_special_word = {in_b[31], EXP_INF, QNAN_FRAC};
    end else if (w_inf) begin
      w_special_word = {in_b[31], EXP_INF, 23'd0};
    end else begin
      w_special_word = {in_b[31], 31'd0};
    end
  end

  assign w_m_zero   = (r_mant == 32'd0);
  assign w_m_carry  = r_mant[31];
  assign w_m_norm   = r_mant[30];
  assign w_m_coarse = (r_mant[30:23] == 8'd0);

  relm_fround u_fround (
    .i_sign (r_sign),
    .i_exp  (r_exp),
    .i_mant (r_mant),
    .o_word (w_word),
    .o_ovf  (w_ovf),
    .o_unf  (w_unf)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  //       samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = w_special ? S_DONE : S_NORM;
      S_NORM: begin
        if (w_m_zero) begin
          w_next = S_DONE;
        end else if (w_m_carry || w_m_norm) begin
          w_next = S_ROUND;
        end
      end
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Datapath: one normalisation rule per NORM cycle, coarse 8-bit shifts
  // keep the worst case (a single set bit) within ten cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_mant <= '0;
      r_data <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= in_b[31];
            r_exp  <= $signed({2'b00, in_b[EXP_MSB:EXP_LSB]});
            r_mant <= in_a;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            if (w_special) r_data <= w_special_word;
          end
        end
        S_NORM: begin
          if (w_m_zero) begin
            r_data <= {r_sign, 31'd0};
          end else if (w_m_carry) begin
            r_mant <= {1'b0, r_mant[31:2], r_mant[1] | r_mant[0]};
            r_exp  <= r_exp + $signed(EW'(1));
          end else if (w_m_norm) begin
            r_mant <= r_mant;
          end else if (w_m_coarse) begin
            r_mant <= r_mant << 8;
            r_exp  <= r_exp - $signed(EW'(8));
          end else begin
            r_mant <= r_mant << 1;
            r_exp  <= r_exp - $signed(EW'(1));
          end
        end
        S_ROUND: begin
          r_data <= w_word;
          r_ovf  <= w_ovf;
          r_unf  <= w_unf;
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_data;
  assign out_ovf  = r_ovf;
  assign out_unf  = r_unf;

endmodule

// File: tb/tb_relm_fpack.sv
// Directed self-checking bench for relm_fpack: latency, rounding, specials,
// saturation, backpressure and asynchronous reset.
module tb_relm_fpack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_unf;

  int n_tests = 0;
  int n_fail  = 0;

  relm_fpack #(.WD(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle. lat counts rising edges from
  // the accept edge (inclusive) until out_valid is seen.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_data,
                        input logic exp_ovf, input logic exp_unf, input bit pop);
    int lat;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    check({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/lat"},  32'(lat), 32'(exp_lat));
    check({tag, "/data"}, out_data, exp_data);
    check({tag, "/ovf"},  {31'd0, out_ovf}, {31'd0, exp_ovf});
    check({tag, "/unf"},  {31'd0, out_unf}, {31'd0, exp_unf});
    if (pop) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check({tag, "/idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst/in_ready",  {31'd0, in_ready},  32'd1);
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/out_data",  out_data, 32'd0);
    check("rst/ovf_unf",   {30'd0, out_ovf, out_unf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst/in_ready", {31'd0, in_ready}, 32'd1);

    // 1.0 + 1.0 with mantissa carry: one NORM cycle, result 2.0.
    run_op("carry",   32'h8000_0000, 32'h3F80_0000, 3, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
    // Guard set with odd lsb rounds up; tie with even lsb stays.
    run_op("rnd_up",  32'h4000_00C0, 32'h3F80_0000, 3, 32'h3F80_0002, 1'b0, 1'b0, 1'b1);
    run_op("rnd_tie", 32'h4000_0040, 32'h3F80_0000, 3, 32'h3F80_0000, 1'b0, 1'b0, 1'b1);
    // All-ones fraction rounds up and carries into the exponent.
    run_op("rnd_cy",  32'h7FFF_FFC0, 32'h3F80_0000, 3, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
    // Specials bypass normalisation.
    run_op("nan",     32'h1234_5678, 32'hFF60_0000, 1, 32'hFFC0_0000, 1'b0, 1'b0, 1'b1);
    run_op("inf",     32'h1234_5678, 32'h7FC0_0000, 1, 32'h7F80_0000, 1'b0, 1'b0, 1'b1);
    run_op("zero",    32'h1234_5678, 32'h8020_0000, 1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    // Zero mantissa: NORM goes straight to DONE.
    run_op("mzero",   32'h0000_0000, 32'hBF80_0000, 2, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    // Exponent 254 plus carry saturates.
    run_op("ovf",     32'h8000_0000, 32'h7F00_0000, 3, 32'h7F80_0000, 1'b1, 1'b0, 1'b1);
    // Exponent 1, one single-bit shift, lands on 0 and flushes.
    run_op("unf",     32'h2000_0000, 32'h8080_0000, 4, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    // Deep cancellation, ten NORM cycles; out_ready held high throughout.
    out_ready = 1'b1;
    run_op("cancel",  32'h0000_0080, 32'h3F80_0000, 12, 32'h3400_0000, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held, new requests ignored while in DONE.
    run_op("bp",      32'h8000_0000, 32'h3F80_0000, 3, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    in_a     = 32'h1234_5678;
    in_b     = 32'h7FC0_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp/data",  out_data, 32'h4000_0000);
      check("bp/hs",    {30'd0, in_ready, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp/release", {30'd0, in_ready, out_valid}, 32'd2);

    // Reset during NORM discards the operation at once.
    in_a     = 32'h0000_0080;
    in_b     = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_norm/hs",   {30'd0, in_ready, out_valid}, 32'd2);
    check("rst_norm/data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 32'h8000_0000, 32'h3F80_0000, 3, 32'h4000_0000, 1'b0, 1'b0, 1'b1);

    // Reset while a saturated result is held in DONE.
    run_op("ovf_hold", 32'h8000_0000, 32'h7F00_0000, 3, 32'h7F80_0000, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_done/hs",   {30'd0, in_ready, out_valid}, 32'd2);
    check("rst_done/flag", {30'd0, out_ovf, out_unf}, 32'd0);
    check("rst_done/data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/relm_fpack.md
RELM_FPACK -- requirements
Module: relm_fpack

Interface
REQ-001 Parameter: WD, 32, datapath width; only 32 is supported.
REQ-002 Port: clk  in  1  single clock; all state on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous and active-high.
REQ-004 Port: in_valid  in  1  raw operand pair present.
REQ-005 Port: in_ready  out  1  block idle, will accept.
REQ-006 Port: in_a  in  WD  raw mantissa; nominal leading one at bit 30, carry at bit 31, bits [6:0] guard/sticky.
REQ-007 Port: in_b  in  WD  raw header: [31] sign, [30:23] biased exponent, [22] inf flag, [21] zero flag, [20:0] ignored.
REQ-008 Port: out_valid  out  1  packed result held.
REQ-009 Port: out_ready  in  1  consumer takes result.
REQ-010 Port: out_data  out  WD  IEEE-754 single result.
REQ-011 Port: out_ovf  out  1  result saturated to infinity by exponent overflow.
REQ-012 Port: out_unf  out  1  result flushed to zero by exponent underflow.

Function
REQ-013 FSM states SHALL be IDLE, NORM, ROUND and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 In IDLE, in_valid SHALL latch sign, 10-bit signed exponent E = in_b[30:23], and mantissa M = in_a.
REQ-015 At accept: inf&zero -> DONE with {sign,8'hFF,1'b1,22'd0}; else inf -> DONE with {sign,8'hFF,23'd0}; else zero -> DONE with {sign,31'd0}; otherwise -> NORM.
REQ-016 Each NORM cycle SHALL apply the first matching rule, one rule per cycle:
 (a) M==0 -> DONE with {sign,31'd0};
 (b) M[31] -> M = {1'b0,M[31:2],M[1]|M[0]}, E+1, go to ROUND;
 (c) M[30] -> go to ROUND;
 (d) M[30:23]==0 -> M<<8, E-8;
 (e) otherwise -> M<<1, E-1.
REQ-017 NORM SHALL last at most 10 cycles for any nonzero M.
REQ-018 ROUND: round to nearest, ties to even. lsb = M[7], guard = M[6], sticky = |M[5:0]; increment when guard & (sticky | lsb).
REQ-019 A mantissa carry out of rounding SHALL increment E.
REQ-020 After rounding, E >= 255 SHALL give {sign,8'hFF,23'd0} with out_ovf=1.
REQ-021 After rounding, E <= 0 SHALL give {sign,31'd0} with out_unf=1.
REQ-022 Otherwise the result SHALL be {sign,E[7:0],M[29:7] rounded}; ROUND always goes to DONE.
REQ-023 DONE SHALL hold out_data, out_ovf and out_unf stable until out_ready; out_ready in DONE SHALL return to IDLE the next cycle, with no same-cycle accept.
REQ-024 Latency from the accept edge T: special input -> out_valid at T+1; normal input -> out_valid at T+2+n, where n = NORM cycle count (1..10).
REQ-025 in_valid outside IDLE and out_ready outside DONE SHALL be ignored.

Reset
REQ-026 rst SHALL force IDLE immediately, including mid-NORM or mid-DONE; the current operation is discarded.
REQ-027 On reset: out_valid=0, in_ready=1, out_data=0, out_ovf=0, out_unf=0, internal M=0, E=0.

Structure
REQ-028 Package relm_fp_pkg SHALL hold the state encoding and the constants EXP_INF=8'hFF, QNAN_FRAC=23'h400000 and EXP_FIELD position [30:23].
REQ-029 Rounding and packing SHALL sit in one combinational sub-module, relm_fround (inputs sign, E, M; outputs word, ovf, unf).

Verification
REQ-030 1.0+1.0 carry: in_b=0x3F800000, in_a=0x80000000 -> out_data=0x40000000 at T+3.
REQ-031 Cancellation: in_b=0x3F800000, in_a=0x00000080 -> 10 NORM cycles, out_data=0x34000000 at T+12.
REQ-032 Rounding with in_b=0x3F800000:
 - in_a=0x400000C0 -> 0x3F800002;
 - in_a=0x40000040 (tie, even) -> 0x3F800000.
REQ-033 Specials: in_b=0xFF600000 (inf&zero) -> 0xFFC00000 at T+1; in_b=0x7F000000, in_a=0x80000000 -> 0x7F800000 with out_ovf=1.
REQ-034 Backpressure: out_ready low 5 cycles in DONE -> out_data stable and in_ready=0 throughout; out_ready high -> in_ready=1 next cycle.
REQ-035 Reset mid-NORM: rst pulsed during the REQ-031 case -> out_valid=0 and in_ready=1 immediately; a fresh REQ-030 stimulus then completes correctly.
